// File: rtl/dsi_tx_pkg.sv
// ============================================================================
// Module      : dsi_tx_pkg
// Description : Shared types, DSI data-type constants and the header ECC
//               function used by the DSI long-packet transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsi_tx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LINE = 3'd1,
        HEADER    = 3'd2,
        PAYLOAD   = 3'd3,
        CRC       = 3'd4,
        GAP       = 3'd5
    } state_t;

    localparam logic [5:0]  DT_RGB565     = 6'h0E;
    localparam logic [5:0]  DT_RGB666     = 6'h1E;
    localparam logic [5:0]  DT_RGB888     = 6'h3E;
    localparam logic [15:0] CRC_SEED      = 16'hFFFF;
    // Reflected form of x^16+x^12+x^5+1 for the LSB-first shift
    localparam logic [15:0] CRC_POLY_LSB  = 16'h8408;

    // DSI 6-bit Hamming code over the 24-bit packet header; bits [7:6] are 0
    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [7:0] e;
        e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        e[6] = 1'b0;
        e[7] = 1'b0;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsi_crc16_x32.sv
// ============================================================================
// Module      : dsi_crc16_x32
// Description : DSI payload CRC-16, four bytes per cycle, byte 0 first,
//               each byte shifted LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsi_crc16_x32
    import dsi_tx_pkg::*;
(
    input  logic        clk_phy,
    input  logic        rst_phy_n,
    input  logic        clear,
    input  logic [31:0] data,
    input  logic [3:0]  byte_en,
    input  logic        enable,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [15:0] w_acc;

    always_comb begin
        w_acc = crc_q;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                for (int i = 0; i < 8; i++) begin
                    if (w_acc[0] ^ data[8*b+i]) begin
                        w_acc = (w_acc >> 1) ^ CRC_POLY_LSB;
                    end else begin
                        w_acc = w_acc >> 1;
                    end
                end
            end
        end
        crc_d = crc_q;
        if (clear) begin
            crc_d = CRC_SEED;
        end else if (enable) begin
            crc_d = w_acc;
        end
    end

    always_ff @(posedge clk_phy or negedge rst_phy_n) begin
        if (!rst_phy_n) begin
            crc_q <= CRC_SEED;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/dsi_tx_long_packet_builder.sv
// ============================================================================
// Module      : dsi_tx_long_packet_builder
// Description : Builds one DSI long packet (header, FIFO payload, CRC) per
//               start request. Define DSI_TX_CRC_EN to compute the CRC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsi_tx_long_packet_builder
    import dsi_tx_pkg::*;
#(
    parameter int WC_W    = 16,
    parameter int HDR_GAP = 0
) (
    input  logic            clk_phy,
    input  logic            rst_phy_n,
    input  logic            start_req,
    input  logic [5:0]      cfg_data_type,
    input  logic [1:0]      cfg_vc,
    input  logic [WC_W-1:0] cfg_word_count,
    input  logic [31:0]     fifo_data,
    input  logic            fifo_not_empty,
    input  logic            fifo_line_ready,
    output logic            fifo_read_ack,
    output logic [31:0]     pkt_data,
    output logic [3:0]      pkt_byte_en,
    output logic            pkt_valid,
    input  logic            pkt_ready,
    output logic            pkt_last,
    output logic            busy,
    output logic            underrun_err,
    input  logic            err_clr
);

    localparam int GAP_W = (HDR_GAP > 1) ? $clog2(HDR_GAP) : 1;

    state_t            state_q, state_d;
    logic [5:0]        dt_q, dt_d;
    logic [1:0]        vc_q, vc_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [WC_W-1:0]   bytes_q, bytes_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              underrun_q, underrun_d;

    logic [23:0]       w_hdr24;
    logic [15:0]       w_crc;
    logic              w_xfer;
    logic              w_stall;

    assign w_hdr24 = {16'(wc_q), vc_q, dt_q};
    assign w_xfer  = pkt_valid & pkt_ready;
    assign w_stall = (state_q == PAYLOAD) & ~fifo_not_empty;

`ifdef DSI_TX_CRC_EN
    dsi_crc16_x32 u_crc (
        .clk_phy   (clk_phy),
        .rst_phy_n (rst_phy_n),
        .clear     (state_q == HEADER),
        .data      (fifo_data),
        .byte_en   (4'hF),
        .enable    ((state_q == PAYLOAD) & w_xfer),
        .crc       (w_crc)
    );
`else
    assign w_crc = 16'h0000;
`endif

    always_comb begin
        state_d    = state_q;
        dt_d       = dt_q;
        vc_d       = vc_q;
        wc_d       = wc_q;
        bytes_d    = bytes_q;
        gap_d      = gap_q;
        // A stall in the same cycle outranks a clear so the event is never lost
        underrun_d = w_stall ? 1'b1 : (err_clr ? 1'b0 : underrun_q);
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    dt_d    = cfg_data_type;
                    vc_d    = cfg_vc;
                    wc_d    = cfg_word_count;
                    bytes_d = cfg_word_count;
                    state_d = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (fifo_line_ready) state_d = HEADER;
            end
            HEADER: begin
                if (w_xfer) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                if (w_xfer) begin
                    bytes_d = bytes_q - WC_W'(4);
                    if (bytes_q <= WC_W'(4)) state_d = CRC;
                end
            end
            CRC: begin
                if (w_xfer) begin
                    if (HDR_GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = GAP_W'(HDR_GAP - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_phy or negedge rst_phy_n) begin
        if (!rst_phy_n) begin
            state_q    <= IDLE;
            dt_q       <= '0;
            vc_q       <= '0;
            wc_q       <= '0;
            bytes_q    <= '0;
            gap_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dt_q       <= dt_d;
            vc_q       <= vc_d;
            wc_q       <= wc_d;
            bytes_q    <= bytes_d;
            gap_q      <= gap_d;
            underrun_q <= underrun_d;
        end
    end

    // Header and CRC words come from captured registers, so they hold while stalled
    always_comb begin
        pkt_valid   = 1'b0;
        pkt_data    = 32'h0;
        pkt_byte_en = 4'h0;
        pkt_last    = 1'b0;
        case (state_q)
            HEADER: begin
                pkt_valid   = 1'b1;
                pkt_data    = {dsi_ecc(w_hdr24), w_hdr24};
                pkt_byte_en = 4'hF;
            end
            PAYLOAD: begin
                pkt_valid   = fifo_not_empty;
                pkt_data    = fifo_data;
                pkt_byte_en = 4'hF;
            end
            CRC: begin
                pkt_valid   = 1'b1;
                pkt_data    = {16'h0, w_crc};
                pkt_byte_en = 4'h3;
                pkt_last    = 1'b1;
            end
            default: ;
        endcase
    end

    assign fifo_read_ack = (state_q == PAYLOAD) & w_xfer;
    assign busy          = (state_q == WAIT_LINE) | (state_q == HEADER) |
                           (state_q == PAYLOAD)   | (state_q == CRC);
    assign underrun_err  = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_dsi_tx_long_packet_builder.sv
// ============================================================================
// Module      : tb_dsi_tx_long_packet_builder
// Description : Directed self-checking bench for dsi_tx_long_packet_builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsi_tx_long_packet_builder;

    logic        clk_phy = 1'b0;
    logic        rst_phy_n = 1'b0;
    logic        start_req = 1'b0;
    logic [5:0]  cfg_data_type = '0;
    logic [1:0]  cfg_vc = '0;
    logic [15:0] cfg_word_count = '0;
    logic [31:0] fifo_data;
    logic        fifo_not_empty;
    logic        fifo_line_ready = 1'b0;
    logic        fifo_read_ack;
    logic [31:0] pkt_data;
    logic [3:0]  pkt_byte_en;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic        pkt_last;
    logic        busy;
    logic        underrun_err;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] fifo_mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pops = 0;
    logic        flush_req = 1'b0;

    logic [31:0] cap_data [0:7];
    logic [3:0]  cap_be   [0:7];
    logic        cap_last [0:7];
    int          cap_n, stab_viol, ack_viol, low_cycles;

    always #5 clk_phy = ~clk_phy;

    dsi_tx_long_packet_builder #(.WC_W(16), .HDR_GAP(0)) dut (
        .clk_phy         (clk_phy),
        .rst_phy_n       (rst_phy_n),
        .start_req       (start_req),
        .cfg_data_type   (cfg_data_type),
        .cfg_vc          (cfg_vc),
        .cfg_word_count  (cfg_word_count),
        .fifo_data       (fifo_data),
        .fifo_not_empty  (fifo_not_empty),
        .fifo_line_ready (fifo_line_ready),
        .fifo_read_ack   (fifo_read_ack),
        .pkt_data        (pkt_data),
        .pkt_byte_en     (pkt_byte_en),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .pkt_last        (pkt_last),
        .busy            (busy),
        .underrun_err    (underrun_err),
        .err_clr         (err_clr)
    );

    // Show-ahead FIFO model
    assign fifo_data      = fifo_mem[rd_ptr & 15];
    assign fifo_not_empty = (wr_ptr != rd_ptr);

    always @(posedge clk_phy) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_read_ack) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

`ifdef DSI_TX_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [31:0] w [0:3], input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 32; i++) begin
                if (c[0] ^ w[k][i]) c = (c >> 1) ^ 16'h8408;
                else                c = c >> 1;
            end
        return c;
    endfunction
`endif

    task automatic push(input logic [31:0] d);
        fifo_mem[wr_ptr & 15] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        @(negedge clk_phy);
        flush_req = 1'b1;
        @(negedge clk_phy);
        flush_req = 1'b0;
    endtask

    task automatic start_pkt(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc);
        @(negedge clk_phy);
        cfg_data_type  = dt;
        cfg_vc         = vc;
        cfg_word_count = wc;
        start_req      = 1'b1;
        @(negedge clk_phy);
        start_req      = 1'b0;
    endtask

    // Records transferred words until pkt_last; mode 1 toggles pkt_ready 1,0,1,0
    task automatic capture(input int mode, input int refill_cycle,
                           input logic [31:0] r0, input logic [31:0] r1, output int timeout);
        logic        stalled, done, started, pl;
        logic [31:0] pd;
        logic [3:0]  pb;
        cap_n = 0; stab_viol = 0; ack_viol = 0; low_cycles = 0;
        stalled = 1'b0; done = 1'b0; started = 1'b0; pd = '0; pb = '0; pl = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk_phy);
            if (c == refill_cycle) begin
                push(r0);
                push(r1);
            end
            pkt_ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
            #1;
            if (stalled && pkt_valid && (pkt_data !== pd || pkt_byte_en !== pb || pkt_last !== pl))
                stab_viol++;
            if (fifo_read_ack && !(pkt_valid && pkt_ready)) ack_viol++;
            if (started && !pkt_valid) low_cycles++;
            if (pkt_valid && pkt_ready) begin
                if (cap_n < 8) begin
                    cap_data[cap_n] = pkt_data;
                    cap_be[cap_n]   = pkt_byte_en;
                    cap_last[cap_n] = pkt_last;
                end
                cap_n++;
                started = 1'b1;
                if (pkt_last) done = 1'b1;
            end
            stalled = pkt_valid && !pkt_ready;
            pd = pkt_data; pb = pkt_byte_en; pl = pkt_last;
        end
        pkt_ready = 1'b1;
        timeout = done ? 0 : 1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_phy);
        #1;
        n_checks++;
        if (pkt_valid !== 1'b0 || fifo_read_ack !== 1'b0 || pkt_last !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: valid=%0b ack=%0b last=%0b want 0 0 0", pkt_valid, fifo_read_ack, pkt_last);
        end
        n_checks++;
        if (pkt_data !== 32'h0 || pkt_byte_en !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_data: data=%h be=%h want 0 0", pkt_data, pkt_byte_en);
        end
        n_checks++;
        if (busy !== 1'b0 || underrun_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: busy=%0b underrun=%0b want 0 0", busy, underrun_err);
        end
        rst_phy_n = 1'b1;
        @(negedge clk_phy);
        #1;
        n_checks++;
        if (busy !== 1'b0 || pkt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_idle: busy=%0b valid=%0b want 0 0", busy, pkt_valid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ed [0:4];
        logic [3:0]  eb [0:4];
        int          to, p0;
        ed[0] = 32'h08000C3E; ed[1] = 32'h11223344; ed[2] = 32'hA5A55A5A; ed[3] = 32'hDEADBEEF;
        ed[4] = 32'h0;
`ifdef DSI_TX_CRC_EN
        begin
            logic [31:0] w [0:3];
            w[0] = ed[1]; w[1] = ed[2]; w[2] = ed[3]; w[3] = '0;
            ed[4] = {16'h0, crc_ref(w, 3)};
        end
`endif
        eb[0] = 4'hF; eb[1] = 4'hF; eb[2] = 4'hF; eb[3] = 4'hF; eb[4] = 4'h3;
        push(ed[1]); push(ed[2]); push(ed[3]);
        fifo_line_ready = 1'b1;
        p0 = pops;
        start_pkt(6'h3E, 2'd0, 16'd12);
        capture(0, -1, '0, '0, to);
        n_checks++;
        if (to != 0 || cap_n != 5) begin
            n_errors++;
            $display("FAIL basic_len: timeout=%0d words=%0d want 0 5", to, cap_n);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (cap_data[k] !== ed[k] || cap_be[k] !== eb[k] || cap_last[k] !== (k == 4)) begin
                n_errors++;
                $display("FAIL basic_word%0d: data=%h be=%h last=%0b want %h %h %0b",
                         k, cap_data[k], cap_be[k], cap_last[k], ed[k], eb[k], (k == 4));
            end
        end
        #2;
        n_checks++;
        if (pops - p0 != 3 || low_cycles != 0 || underrun_err !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_flow: pops=%0d gaps=%0d underrun=%0b want 3 0 0", pops - p0, low_cycles, underrun_err);
        end
    endtask

    task automatic test_crc_zero();
        logic [15:0] ec;
        int          to;
        ec = 16'h0000;
`ifdef DSI_TX_CRC_EN
        begin
            logic [31:0] w [0:3];
            w[0] = '0; w[1] = '0; w[2] = '0; w[3] = '0;
            ec = crc_ref(w, 1);
        end
`endif
        push(32'h0);
        start_pkt(6'h3E, 2'd0, 16'd4);
        capture(0, -1, '0, '0, to);
        n_checks++;
        if (to != 0 || cap_n != 3 || cap_data[0] !== 32'h2D00043E) begin
            n_errors++;
            $display("FAIL crc_zero_hdr: words=%0d hdr=%h want 3 2d00043e", cap_n, cap_data[0]);
        end
        n_checks++;
        if (cap_data[2] !== {16'h0, ec} || cap_be[2] !== 4'h3 || cap_last[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL crc_zero_word: data=%h be=%h last=%0b want %h 3 1", cap_data[2], cap_be[2], cap_last[2], {16'h0, ec});
        end
    endtask

    task automatic test_ready_toggle();
        int to, p0;
        push(32'h01020304); push(32'h05060708); push(32'h090A0B0C);
        p0 = pops;
        start_pkt(6'h3E, 2'd0, 16'd12);
        // Mid-packet cfg edits must not reach the header
        cfg_word_count = 16'd40;
        cfg_data_type  = 6'h0E;
        cfg_vc         = 2'd3;
        capture(1, -1, '0, '0, to);
        #2;
        n_checks++;
        if (to != 0 || cap_n != 5 || cap_data[0] !== 32'h08000C3E) begin
            n_errors++;
            $display("FAIL toggle_hdr: words=%0d hdr=%h want 5 08000c3e", cap_n, cap_data[0]);
        end
        n_checks++;
        if (cap_data[1] !== 32'h01020304 || cap_data[2] !== 32'h05060708 || cap_data[3] !== 32'h090A0B0C) begin
            n_errors++;
            $display("FAIL toggle_payload: %h %h %h want 01020304 05060708 090a0b0c", cap_data[1], cap_data[2], cap_data[3]);
        end
        n_checks++;
        if (ack_viol != 0 || stab_viol != 0) begin
            n_errors++;
            $display("FAIL toggle_stall: pop_without_xfer=%0d unstable=%0d want 0 0", ack_viol, stab_viol);
        end
        n_checks++;
        if (pops - p0 != 3) begin
            n_errors++;
            $display("FAIL toggle_pops: got %0d want 3", pops - p0);
        end
    endtask

    task automatic test_underrun();
        int to, p0;
        push(32'hAAAA0001); push(32'hAAAA0002);
        p0 = pops;
        start_pkt(6'h3E, 2'd0, 16'd16);
        capture(0, 8, 32'hAAAA0003, 32'hAAAA0004, to);
        #2;
        n_checks++;
        if (to != 0 || cap_n != 6 || cap_data[0] !== 32'h2800103E) begin
            n_errors++;
            $display("FAIL underrun_len: words=%0d hdr=%h want 6 2800103e", cap_n, cap_data[0]);
        end
        n_checks++;
        if (cap_data[3] !== 32'hAAAA0003 || cap_data[4] !== 32'hAAAA0004 || cap_last[5] !== 1'b1) begin
            n_errors++;
            $display("FAIL underrun_tail: %h %h last=%0b want aaaa0003 aaaa0004 1", cap_data[3], cap_data[4], cap_last[5]);
        end
        n_checks++;
        if (low_cycles != 5 || pops - p0 != 4) begin
            n_errors++;
            $display("FAIL underrun_stall: valid_low=%0d pops=%0d want 5 4", low_cycles, pops - p0);
        end
        n_checks++;
        if (underrun_err !== 1'b1) begin
            n_errors++;
            $display("FAIL underrun_flag: got %0b want 1", underrun_err);
        end
        @(negedge clk_phy);
        err_clr = 1'b1;
        @(negedge clk_phy);
        err_clr = 1'b0;
        #1;
        n_checks++;
        if (underrun_err !== 1'b0) begin
            n_errors++;
            $display("FAIL underrun_clear: got %0b want 0", underrun_err);
        end
    endtask

    task automatic test_busy_ignore();
        int to, extra;
        fifo_line_ready = 1'b0;
        push(32'hCAFE0001); push(32'hCAFE0002);
        start_pkt(6'h3E, 2'd0, 16'd8);
        #1;
        n_checks++;
        if (busy !== 1'b1 || pkt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_line: busy=%0b valid=%0b want 1 0", busy, pkt_valid);
        end
        start_pkt(6'h0E, 2'd1, 16'd4);
        fifo_line_ready = 1'b1;
        capture(0, -1, '0, '0, to);
        n_checks++;
        if (to != 0 || cap_n != 4 || cap_data[0] !== 32'h2B00083E) begin
            n_errors++;
            $display("FAIL ignore_start: words=%0d hdr=%h want 4 2b00083e", cap_n, cap_data[0]);
        end
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_phy);
            #1;
            if (pkt_valid || busy) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_errors++;
            $display("FAIL no_queued_pkt: active_cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int p0, to;
        push(32'h5A5A0001); push(32'h5A5A0002); push(32'h5A5A0003);
        p0 = pops;
        start_pkt(6'h3E, 2'd0, 16'd12);
        to = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_phy);
            #1;
            if (pops != p0) begin
                to = 0;
                break;
            end
        end
        n_checks++;
        if (to != 0 || pkt_valid !== 1'b1 || pkt_data !== 32'h5A5A0002) begin
            n_errors++;
            $display("FAIL reset_mid_setup: timeout=%0d valid=%0b data=%h want 0 1 5a5a0002", to, pkt_valid, pkt_data);
        end
        rst_phy_n = 1'b0;
        #1;
        n_checks++;
        if (pkt_valid !== 1'b0 || fifo_read_ack !== 1'b0 || pkt_data !== 32'h0 ||
            pkt_byte_en !== 4'h0 || pkt_last !== 1'b0 || busy !== 1'b0 || underrun_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: valid=%0b ack=%0b data=%h be=%h last=%0b busy=%0b want all 0",
                     pkt_valid, fifo_read_ack, pkt_data, pkt_byte_en, pkt_last, busy);
        end
        @(negedge clk_phy);
        rst_phy_n = 1'b1;
        @(negedge clk_phy);
        #1;
        n_checks++;
        if (busy !== 1'b0 || pkt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_idle: busy=%0b valid=%0b want 0 0", busy, pkt_valid);
        end
        flush();
        push(32'h77777777);
        start_pkt(6'h3E, 2'd0, 16'd4);
        capture(0, -1, '0, '0, to);
        n_checks++;
        if (to != 0 || cap_n != 3 || cap_data[1] !== 32'h77777777) begin
            n_errors++;
            $display("FAIL reset_recover: words=%0d payload=%h want 3 77777777", cap_n, cap_data[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_zero();
        test_ready_toggle();
        test_underrun();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
